eth_tx_frame_arbiter: RTL and testbench
=======================================

// Module: eth_tx_frame_arbiter
//
// PURPOSE
// Frame-level round-robin arbiter that shares one 8-bit MAC TX AXI stream among PORTS requesters.
// Sits in the logic clock domain, directly ahead of the TX FIFO input of the 1G MAC/FIFO wrapper.
// Holds each grant for a whole frame and never interleaves frames.
// Enforces a maximum frame length: oversize frames are truncated and marked bad (tuser=1),
// so the frame FIFO drops them.
//
// PARAMETERS
// PORTS          4     number of requesters, 2..8
// MAX_FRAME_LEN  1518  max bytes forwarded per frame, >=2
// LEN_WIDTH      16    byte counter width; must satisfy 2**LEN_WIDTH > MAX_FRAME_LEN
//
// PORTS
// logic_clk          in   1            clock
// logic_rst_n        in   1            asynchronous reset, active low
// s_axis_tdata       in   PORTS*8      requester data; port i uses bits [8*i+7:8*i]
// s_axis_tvalid      in   PORTS        per-port valid
// s_axis_tready      out  PORTS        per-port ready
// s_axis_tlast       in   PORTS        per-port end of frame
// s_axis_tuser       in   PORTS        per-port bad-frame flag
// m_axis_tdata       out  8            to TX FIFO
// m_axis_tvalid      out  1
// m_axis_tready      in   1
// m_axis_tlast       out  1
// m_axis_tuser       out  1            1 = bad frame
// grant_valid        out  1            a frame is in progress (XFER or DISCARD)
// grant_index        out  $clog2(PORTS)  port currently owning the output
// status_truncated   out  1            1-cycle pulse when an oversize frame is cut
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE, grant_index=0, grant_valid=0, status_truncated=0, byte count=0.
//   - RR pointer=PORTS-1, so port 0 wins first.
//   - All s_axis_tready=0 and m_axis_tvalid=0 while in reset and in IDLE.
// - IDLE:
//   - If any s_axis_tvalid is set, grant the first asserted port scanning upward from pointer+1 (wrapping).
//   - Register grant_index, set grant_valid, go to XFER.
//   - Arbitration costs exactly 1 idle cycle; no data moves in IDLE.
// - XFER (pass-through, combinational, zero latency):
//   - m_axis_tdata/tvalid/tlast/tuser = granted port's signals.
//   - s_axis_tready[g] = m_axis_tready; every other tready = 0.
//   - A beat is a cycle with m_axis_tvalid & m_axis_tready; the count increments per beat.
//   - Beat with tlast, count < MAX_FRAME_LEN-1: frame done. Pointer=g, count=0, grant_valid=0 -> IDLE.
//   - Beat with count == MAX_FRAME_LEN-1: force m_axis_tlast=1 and m_axis_tuser=1 on that beat,
//     pulse status_truncated next cycle, pointer=g, count=0.
//     - If the input tlast is 1 on that beat, go to IDLE (frame exactly MAX: still marked bad; no DISCARD).
//     - Otherwise go to DISCARD.
// - DISCARD:
//   - m_axis_tvalid=0; s_axis_tready[g]=1; input beats are consumed and dropped.
//   - On an input beat with tlast -> IDLE, grant_valid=0.
// - Requester tvalid dropping mid-frame: the grant is held (no timeout); m_axis_tvalid follows it.
// - Non-granted requesters are never acknowledged; their tvalid/tdata must stay stable (AXIS rule).
// - A requester re-requesting right after its own frame loses to any other pending port (strict RR).
// - Reset mid-frame: output aborts immediately with no tlast; the downstream FIFO is reset alongside.
//
// TESTING
// - Ports 0 and 2 each hold a 64-byte frame at reset release ->
//   port 0 frame out intact, 1 idle cycle, then port 2; grant_index 0 then 2.
// - All 4 ports request continuously (10-byte frames) -> grant order 0,1,2,3,0;
//   exactly 1 gap cycle per frame; no interleave.
// - m_axis_tready toggled 1010... during a 20-byte frame ->
//   20 beats out in order, granted port sees tready mirror it, others stay 0.
// - MAX_FRAME_LEN=16, port 1 sends 40 bytes ->
//   16 beats out, beat 16 has tlast=1/tuser=1, status_truncated one pulse,
//   24 bytes drained with m_axis_tvalid=0, then IDLE.
// - MAX_FRAME_LEN=16, frame of exactly 16 bytes ->
//   tlast=1, tuser=1, no DISCARD cycles; 15-byte frame -> tuser = input tuser.
// - logic_rst_n pulsed low at byte 5 of a frame ->
//   outputs 0 immediately; after release port 0 is granted first.

Source files
------------

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-level round-robin arbiter that shares one 8-bit AXI stream
// (the MAC TX FIFO input) among PORTS requesters. A grant is held for a whole frame, so frames
// never interleave. A frame longer than MAX_FRAME_LEN is cut: the last forwarded beat carries
// tlast=1/tuser=1, and the rest of the input frame is consumed and dropped.
//
// Ports:
//   logic_clk, logic_rst_n   clock, asynchronous active-low reset
//   s_axis_*                 per-requester AXI stream inputs (port i data in bits [8*i+7:8*i])
//   m_axis_*                 shared output stream, tuser=1 marks a bad frame
//   grant_valid              a frame is in progress (transfer or discard)
//   grant_index              port that currently owns the output
//   status_truncated         one-cycle pulse after an oversize frame is cut
module eth_tx_frame_arbiter #(
  parameter int unsigned PORTS         = 4,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned LEN_WIDTH     = 16,
  localparam int unsigned IdxW         = $clog2(PORTS)
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst_n,
  input  logic [PORTS*8-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]     s_axis_tvalid,
  output logic [PORTS-1:0]     s_axis_tready,
  input  logic [PORTS-1:0]     s_axis_tlast,
  input  logic [PORTS-1:0]     s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 grant_valid,
  output logic [IdxW-1:0]      grant_index,
  output logic                 status_truncated
);

  typedef enum logic [1:0] {StIdle, StXfer, StDiscard} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic                 gv_q, gv_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 trunc_q, trunc_d;

  // Round-robin search starting just above the last served port.
  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  logic [IdxW-1:0] cand;
  int unsigned     sum;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      sum  = (32'(ptr_q) + i) % PORTS;
      cand = IdxW'(sum);
      if (!arb_found && s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Signals of the granted port.
  logic [7:0]       sel_data;
  logic             sel_valid, sel_last, sel_user;
  logic [PORTS-1:0] grant_oh;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    grant_oh  = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (grant_q == IdxW'(p)) begin
        sel_data    = s_axis_tdata[8*p +: 8];
        sel_valid   = s_axis_tvalid[p];
        sel_last    = s_axis_tlast[p];
        sel_user    = s_axis_tuser[p];
        grant_oh[p] = 1'b1;
      end
    end
  end

  logic at_max;
  assign at_max = (count_q == LEN_WIDTH'(MAX_FRAME_LEN - 1));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    gv_d          = gv_q;
    count_d       = count_q;
    trunc_d       = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d = arb_idx;
          gv_d    = 1'b1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        m_axis_tdata  = sel_data;
        m_axis_tvalid = sel_valid;
        // The beat that reaches the length limit always closes the frame as bad.
        m_axis_tlast  = sel_last | at_max;
        m_axis_tuser  = sel_user | at_max;
        s_axis_tready = grant_oh & {PORTS{m_axis_tready}};
        if (sel_valid && m_axis_tready) begin
          if (at_max) begin
            trunc_d = 1'b1;
            ptr_d   = grant_q;
            count_d = '0;
            if (sel_last) begin
              gv_d    = 1'b0;
              state_d = StIdle;
            end else begin
              state_d = StDiscard;
            end
          end else if (sel_last) begin
            ptr_d   = grant_q;
            count_d = '0;
            gv_d    = 1'b0;
            state_d = StIdle;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StDiscard: begin
        s_axis_tready = grant_oh;
        if (sel_valid && sel_last) begin
          gv_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= IdxW'(PORTS - 1);
      gv_q    <= 1'b0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gv_q    <= gv_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

  assign grant_valid      = gv_q;
  assign grant_index      = grant_q;
  assign status_truncated = trunc_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter (PORTS=4, MAX_FRAME_LEN=16). Per-port source queues drive the
// requesters; expected output beats are queued in the order the arbiter must serve them and a
// monitor pops and compares every accepted output beat.
module tb_eth_tx_frame_arbiter;

  localparam int Ports = 4;
  localparam int MaxLen = 16;

  typedef struct packed {logic [7:0] d; logic l; logic u;} src_t;
  typedef struct packed {logic [1:0] p; logic [7:0] d; logic l; logic u;} exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      s_tdata = '0;
  logic [3:0]       s_tvalid = '0;
  logic [3:0]       s_tready;
  logic [3:0]       s_tlast = '0;
  logic [3:0]       s_tuser = '0;
  logic [7:0]       m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic             m_tuser;
  logic             gv;
  logic [1:0]       gidx;
  logic             trunc;

  eth_tx_frame_arbiter #(
    .PORTS        (Ports),
    .MAX_FRAME_LEN(MaxLen),
    .LEN_WIDTH    (5)
  ) dut (
    .logic_clk       (clk),
    .logic_rst_n     (rst_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser    (m_tuser),
    .grant_valid     (gv),
    .grant_index     (gidx),
    .status_truncated(trunc)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   mon_beats = 0;
  int   trunc_cnt = 0;
  src_t src_q[4][$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Requester model: a beat fires on valid&ready at the negedge, next beat shows after posedge.
  initial begin
    logic [3:0] fire;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < Ports; p++) begin
        if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          s_tvalid[p]       = 1'b1;
          s_tdata[8*p +: 8] = src_q[p][0].d;
          s_tlast[p]        = src_q[p][0].l;
          s_tuser[p]        = src_q[p][0].u;
        end else begin
          s_tvalid[p]       = 1'b0;
          s_tdata[8*p +: 8] = '0;
          s_tlast[p]        = 1'b0;
          s_tuser[p]        = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_tvalid && m_tready) begin
      mon_beats++;
      if (sb.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        e = sb.pop_front();
        chk("beat", 32'({gidx, m_tdata, m_tlast, m_tuser}), 32'(e));
      end
    end
  end

  always @(negedge clk) if (rst_n && trunc) trunc_cnt++;

  function automatic logic [7:0] bval(input int p, input int k);
    return 8'(p * 64 + k);
  endfunction

  task automatic load(input int p, input int len, input logic ulast);
    for (int k = 0; k < len; k++)
      src_q[p].push_back('{d: bval(p, k), l: (k == len - 1), u: ulast && (k == len - 1)});
  endtask

  // Expected output of one input frame: cut at MaxLen beats, bad if it reaches the limit.
  task automatic expect_frame(input int p, input int len, input logic ulast);
    int  olen;
    logic u;
    olen = (len > MaxLen) ? MaxLen : len;
    for (int k = 0; k < olen; k++) begin
      u = (len >= MaxLen) ? (k == MaxLen - 1) : (ulast && (k == len - 1));
      sb.push_back('{p: 2'(p), d: bval(p, k), l: (k == olen - 1), u: u});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_tready = 1'b1;
    for (int p = 0; p < Ports; p++) src_q[p].delete();
    sb.delete();
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_grant_valid", 32'(gv), 0);
    chk("rst_grant_index", 32'(gidx), 0);
    chk("rst_truncated", 32'(trunc), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_tready", 32'(s_tready), 0);
    chk("idle_m_tvalid", 32'(m_tvalid), 0);
    trunc_cnt = 0;
  endtask

  // Wait for nbeats output beats; gaps counts beat-less cycles after the first beat.
  task automatic run_beats(input int nbeats, output int gaps);
    int seen = 0;
    int n = 0;
    gaps = 0;
    while (seen < nbeats && n < 2000) begin
      @(negedge clk);
      n++;
      if (m_tvalid && m_tready) seen++;
      else if (seen > 0) gaps++;
    end
    if (seen < nbeats) fail_now("beat_timeout");
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    int gaps;
    int seen;
    int n;
    int disc;
    int base;

    // Ports 0 and 2 pending at reset release: port 0 first, one idle cycle, then port 2.
    do_reset();
    load(0, 12, 1'b0);
    load(2, 12, 1'b0);
    expect_frame(0, 12, 1'b0);
    expect_frame(2, 12, 1'b0);
    run_beats(24, gaps);
    chk("t1_gaps", 32'(gaps), 1);
    wait_sb_empty();

    // All ports requesting: order 0,1,2,3,0 with one gap per frame.
    do_reset();
    for (int p = 0; p < Ports; p++) load(p, 10, 1'b0);
    load(0, 10, 1'b0);
    for (int p = 0; p < Ports; p++) expect_frame(p, 10, 1'b0);
    expect_frame(0, 10, 1'b0);
    run_beats(50, gaps);
    chk("t2_gaps", 32'(gaps), 4);
    wait_sb_empty();

    // Toggling m_tready on a port-1 frame while port 3 waits.
    do_reset();
    load(1, 14, 1'b0);
    load(3, 6, 1'b0);
    expect_frame(1, 14, 1'b0);
    expect_frame(3, 6, 1'b0);
    seen = 0;
    n = 0;
    while (seen < 14 && n < 500) begin
      @(posedge clk);
      #1 m_tready = ~m_tready;
      @(negedge clk);
      n++;
      if (m_tvalid && m_tready) seen++;
      chk("tready_mirror", 32'(s_tready), (gv && m_tready) ? 32'h2 : 32'h0);
    end
    if (seen < 14) fail_now("t3_timeout");
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_sb_empty();

    // Oversize frame: 16 beats out, last bad, 24 dropped, one truncation pulse.
    do_reset();
    load(1, 40, 1'b0);
    expect_frame(1, 40, 1'b0);
    disc = 0;
    n = 0;
    while (src_q[1].size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
      if (gv && !m_tvalid) disc++;
    end
    if (src_q[1].size() > 0) fail_now("t4_timeout");
    @(negedge clk);
    chk("t4_discard_cycles", 32'(disc), 24);
    chk("t4_trunc_pulses", 32'(trunc_cnt), 1);
    chk("t4_idle_after", 32'(gv), 0);
    wait_sb_empty();

    // Exactly MaxLen: bad, no discard; MaxLen-1: input tuser passes through.
    do_reset();
    load(2, 16, 1'b0);
    load(2, 15, 1'b1);
    load(2, 15, 1'b0);
    expect_frame(2, 16, 1'b0);
    expect_frame(2, 15, 1'b1);
    expect_frame(2, 15, 1'b0);
    disc = 0;
    n = 0;
    while ((sb.size() > 0 || src_q[2].size() > 0) && n < 500) begin
      @(negedge clk);
      n++;
      if (gv && !m_tvalid) disc++;
    end
    @(negedge clk);
    chk("t5_discard_cycles", 32'(disc), 0);
    chk("t5_trunc_pulses", 32'(trunc_cnt), 1);
    wait_sb_empty();

    // Reset mid-frame: outputs drop at once, port 0 wins first afterwards.
    do_reset();
    load(2, 12, 1'b0);
    expect_frame(2, 12, 1'b0);
    base = mon_beats;
    n = 0;
    while (mon_beats < base + 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (mon_beats < base + 5) fail_now("t6_timeout");
    #3 rst_n = 1'b0;
    #1;
    chk("t6_m_tvalid", 32'(m_tvalid), 0);
    chk("t6_m_tlast", 32'(m_tlast), 0);
    chk("t6_s_tready", 32'(s_tready), 0);
    chk("t6_grant_valid", 32'(gv), 0);
    chk("t6_grant_index", 32'(gidx), 0);
    for (int p = 0; p < Ports; p++) src_q[p].delete();
    sb.delete();
    s_tvalid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load(3, 6, 1'b0);
    load(0, 6, 1'b0);
    expect_frame(0, 6, 1'b0);
    expect_frame(3, 6, 1'b0);
    wait_sb_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
